// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU request port, NIC request port and the
// registered data-memory port. master = requester/memory side, slave = arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              nic_req;
    logic              nic_wr;
    logic [ADDR_W-1:0] nic_addr;
    logic [DATA_W-1:0] nic_wdata;
    logic              nic_gnt;
    logic              nic_rvalid;
    logic [DATA_W-1:0] nic_rdata;

    logic              mem_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output nic_req, nic_wr, nic_addr, nic_wdata,
        input  nic_gnt, nic_rvalid, nic_rdata,
        input  mem_en, mem_wr_en, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  nic_req, nic_wr, nic_addr, nic_wdata,
        output nic_gnt, nic_rvalid, nic_rdata,
        output mem_en, mem_wr_en, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one registered data-memory port between the CPU (port 0) and NIC (port 1).
// Round-robin by default; define DMEM_ARB_CPU_PRIORITY_EN for CPU priority with NIC starvation relief.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {PORT_CPU = 1'b0, PORT_NIC = 1'b1} port_e;

    port_e             last_gnt;
    port_e             winner;
    logic [CNT_W-1:0]  starve_cnt;
    logic              cpu_gnt;
    logic              nic_gnt;
    logic              any_gnt;
    logic              win_wr;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    logic              mem_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // Return tag: stage 1 lines up with mem_en, stage 2 with mem_rdata.
    logic              s1_valid;
    logic              s1_read;
    port_e             s1_id;
    logic              s2_valid;
    logic              s2_read;
    port_e             s2_id;

    logic              cpu_rvalid;
    logic              nic_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic [DATA_W-1:0] nic_rdata;

    always_comb begin
        cpu_gnt = 1'b0;
        nic_gnt = 1'b0;
        if (!reset) begin
            if (bus.cpu_req && bus.nic_req) begin
`ifdef DMEM_ARB_CPU_PRIORITY_EN
                if (starve_cnt == CNT_W'(STARVE_MAX - 1)) nic_gnt = 1'b1;
                else                                      cpu_gnt = 1'b1;
`else
                if (last_gnt == PORT_NIC) cpu_gnt = 1'b1;
                else                      nic_gnt = 1'b1;
`endif
            end else begin
                cpu_gnt = bus.cpu_req;
                nic_gnt = bus.nic_req;
            end
        end
    end

    always_comb begin
        any_gnt   = cpu_gnt | nic_gnt;
        winner    = nic_gnt ? PORT_NIC : PORT_CPU;
        win_wr    = nic_gnt ? bus.nic_wr    : bus.cpu_wr;
        win_addr  = nic_gnt ? bus.nic_addr  : bus.cpu_addr;
        win_wdata = nic_gnt ? bus.nic_wdata : bus.cpu_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt   <= PORT_NIC;
            starve_cnt <= '0;
            mem_en     <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            s1_valid   <= 1'b0;
            s1_read    <= 1'b0;
            s1_id      <= PORT_CPU;
            s2_valid   <= 1'b0;
            s2_read    <= 1'b0;
            s2_id      <= PORT_CPU;
            cpu_rvalid <= 1'b0;
            nic_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            nic_rdata  <= '0;
        end else begin
            mem_en    <= any_gnt;
            mem_wr_en <= any_gnt & win_wr;
            if (any_gnt) begin
                mem_addr  <= win_addr;
                mem_wdata <= win_wdata;
                last_gnt  <= winner;
            end

            s1_valid <= any_gnt;
            s1_read  <= ~win_wr;
            s1_id    <= winner;
            s2_valid <= s1_valid;
            s2_read  <= s1_read;
            s2_id    <= s1_id;

            cpu_rvalid <= s2_valid & s2_read & (s2_id == PORT_CPU);
            nic_rvalid <= s2_valid & s2_read & (s2_id == PORT_NIC);
            if (s2_valid && s2_read && s2_id == PORT_CPU) cpu_rdata <= bus.mem_rdata;
            if (s2_valid && s2_read && s2_id == PORT_NIC) nic_rdata <= bus.mem_rdata;

`ifdef DMEM_ARB_CPU_PRIORITY_EN
            // A NIC request that is not granted can only have lost contention.
            if (nic_gnt || !bus.nic_req) starve_cnt <= '0;
            else                         starve_cnt <= starve_cnt + 1'b1;
`else
            starve_cnt <= '0;
`endif
        end
    end

`ifndef DMEM_ARB_CPU_PRIORITY_EN
    logic unused_starve;
    assign unused_starve = ^starve_cnt;
`endif

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.nic_gnt    = nic_gnt;
    assign bus.mem_en     = mem_en;
    assign bus.mem_wr_en  = mem_wr_en;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.nic_rvalid = nic_rvalid;
    assign bus.cpu_rdata  = cpu_rdata;
    assign bus.nic_rdata  = nic_rdata;
endmodule
